// File: rtl/instr_encoder.sv
// ----------------------------------------------------------------------------
// instr_encoder
//
// Turns a small symbolic instruction request (operation select, register
// indices, immediate) into a 32-bit RV32I machine word behind a single
// valid/ready output register stage. Every emitted word is tagged with its
// byte address, starting at BASE_ADDR after reset and advancing by 4 on each
// accepted output. Requests with an illegal op_sel or an out-of-range
// immediate are replaced by a NOP (addi x0, x0, 0) flagged with out_err. The
// NOP still takes an address, so the surrounding words keep their addresses.
//
// Ports
//   clk        in   1   clock, all state updates on the rising edge
//   rst        in   1   synchronous active-high reset
//   in_valid   in   1   request present on op_sel/rd/rs1/rs2/imm
//   in_ready   out  1   encoder can take a request this cycle
//   op_sel     in   4   operation select (14-15 illegal)
//   rd         in   5   destination register index
//   rs1        in   5   first source register index
//   rs2        in   5   second source register index
//   imm        in   32  signed byte offset / immediate (full value for LUI)
//   out_valid  out  1   out_instr/out_addr/out_err hold a word
//   out_ready  in   1   consumer takes the word
//   out_instr  out  32  encoded instruction word
//   out_addr   out  32  byte address of out_instr
//   out_err    out  1   word is a substituted NOP
//   err_count  out  8   saturating count of emitted error words
// ----------------------------------------------------------------------------
module instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  op_sel,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        out_err,
    output logic [7:0]  err_count
);

    // Operation select codes
    localparam logic [3:0] OpAdd  = 4'd0;
    localparam logic [3:0] OpSub  = 4'd1;
    localparam logic [3:0] OpAddi = 4'd2;
    localparam logic [3:0] OpLbu  = 4'd3;
    localparam logic [3:0] OpLw   = 4'd4;
    localparam logic [3:0] OpSb   = 4'd5;
    localparam logic [3:0] OpSw   = 4'd6;
    localparam logic [3:0] OpLui  = 4'd7;
    localparam logic [3:0] OpBne  = 4'd8;
    localparam logic [3:0] OpBgeu = 4'd9;
    localparam logic [3:0] OpJal  = 4'd10;
    localparam logic [3:0] OpJalr = 4'd11;
    localparam logic [3:0] OpSlli = 4'd12;
    localparam logic [3:0] OpSrai = 4'd13;

    // RV32I major opcodes
    localparam logic [6:0] OpcOp     = 7'h33;
    localparam logic [6:0] OpcOpImm  = 7'h13;
    localparam logic [6:0] OpcLoad   = 7'h03;
    localparam logic [6:0] OpcStore  = 7'h23;
    localparam logic [6:0] OpcLui    = 7'h37;
    localparam logic [6:0] OpcBranch = 7'h63;
    localparam logic [6:0] OpcJal    = 7'h6F;
    localparam logic [6:0] OpcJalr   = 7'h67;

    localparam logic [31:0] Nop = 32'h0000_0013;

    // Immediate range limits
    localparam logic signed [31:0] ImmIMin = -32'sd2048;
    localparam logic signed [31:0] ImmIMax = 32'sd2047;
    localparam logic signed [31:0] ImmBMin = -32'sd4096;
    localparam logic signed [31:0] ImmBMax = 32'sd4094;
    localparam logic signed [31:0] ImmJMin = -32'sd1048576;
    localparam logic signed [31:0] ImmJMax = 32'sd1048574;

    // ------------------------------------------------------------------------
    // Output register stage state
    // ------------------------------------------------------------------------
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic        out_err_q,   out_err_d;
    // Address of the word currently held, or of the next word when empty.
    // It only moves on an output handshake, so it never drifts with in_valid.
    logic [31:0] addr_q,      addr_d;
    logic [7:0]  err_cnt_q,   err_cnt_d;

    logic out_hs;
    logic in_hs;

    // ------------------------------------------------------------------------
    // Immediate range checks
    // ------------------------------------------------------------------------
    logic signed [31:0] imm_s;
    logic               fits_i;
    logic               fits_b;
    logic               fits_j;
    logic               fits_u;
    logic               fits_sh;

    assign imm_s   = $signed(imm);
    assign fits_i  = (imm_s >= ImmIMin) && (imm_s <= ImmIMax);
    assign fits_b  = (imm_s >= ImmBMin) && (imm_s <= ImmBMax) && !imm[0];
    assign fits_j  = (imm_s >= ImmJMin) && (imm_s <= ImmJMax) && !imm[0];
    assign fits_u  = (imm[11:0] == 12'h000);
    // Treating imm as unsigned also rejects negative shift amounts
    assign fits_sh = (imm[31:5] == 27'd0);

    // ------------------------------------------------------------------------
    // Encoder
    // ------------------------------------------------------------------------
    logic [31:0] enc_raw;
    logic        enc_ok;
    logic [31:0] enc_instr;
    logic        enc_err;

    always_comb begin
        enc_raw = Nop;
        enc_ok  = 1'b0;
        case (op_sel)
            OpAdd: begin
                enc_raw = {7'h00, rs2, rs1, 3'b000, rd, OpcOp};
                enc_ok  = 1'b1;
            end
            OpSub: begin
                enc_raw = {7'h20, rs2, rs1, 3'b000, rd, OpcOp};
                enc_ok  = 1'b1;
            end
            OpAddi: begin
                enc_raw = {imm[11:0], rs1, 3'b000, rd, OpcOpImm};
                enc_ok  = fits_i;
            end
            OpLbu: begin
                enc_raw = {imm[11:0], rs1, 3'b100, rd, OpcLoad};
                enc_ok  = fits_i;
            end
            OpLw: begin
                enc_raw = {imm[11:0], rs1, 3'b010, rd, OpcLoad};
                enc_ok  = fits_i;
            end
            OpSb: begin
                enc_raw = {imm[11:5], rs2, rs1, 3'b000, imm[4:0], OpcStore};
                enc_ok  = fits_i;
            end
            OpSw: begin
                enc_raw = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OpcStore};
                enc_ok  = fits_i;
            end
            OpLui: begin
                enc_raw = {imm[31:12], rd, OpcLui};
                enc_ok  = fits_u;
            end
            OpBne: begin
                enc_raw = {imm[12], imm[10:5], rs2, rs1, 3'b001, imm[4:1], imm[11],
                           OpcBranch};
                enc_ok  = fits_b;
            end
            OpBgeu: begin
                enc_raw = {imm[12], imm[10:5], rs2, rs1, 3'b111, imm[4:1], imm[11],
                           OpcBranch};
                enc_ok  = fits_b;
            end
            OpJal: begin
                enc_raw = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OpcJal};
                enc_ok  = fits_j;
            end
            OpJalr: begin
                enc_raw = {imm[11:0], rs1, 3'b000, rd, OpcJalr};
                enc_ok  = fits_i;
            end
            OpSlli: begin
                enc_raw = {7'h00, imm[4:0], rs1, 3'b001, rd, OpcOpImm};
                enc_ok  = fits_sh;
            end
            OpSrai: begin
                enc_raw = {7'h20, imm[4:0], rs1, 3'b101, rd, OpcOpImm};
                enc_ok  = fits_sh;
            end
            default: begin
                enc_raw = Nop;
                enc_ok  = 1'b0;
            end
        endcase
    end

    assign enc_instr = enc_ok ? enc_raw : Nop;
    assign enc_err   = !enc_ok;

    // ------------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------------
    // Ready is held high in reset even if a stalled word is about to be
    // discarded; acceptance is still blocked by rst below.
    assign in_ready = rst || !out_valid_q || out_ready;
    assign out_hs   = out_valid_q && out_ready;
    assign in_hs    = in_valid && in_ready && !rst;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_err_d   = out_err_q;
        addr_d      = addr_q;
        err_cnt_d   = err_cnt_q;

        if (out_hs) begin
            addr_d = addr_q + 32'd4;
            if (out_err_q && (err_cnt_q != 8'hFF)) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end

        if (in_hs) begin
            out_valid_d = 1'b1;
            out_instr_d = enc_instr;
            out_err_d   = enc_err;
        end else if (out_hs) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_instr_q <= 32'h0000_0000;
            out_err_q   <= 1'b0;
            addr_q      <= BASE_ADDR;
            err_cnt_q   <= 8'h00;
        end else begin
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_err_q   <= out_err_d;
            addr_q      <= addr_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_err   = out_err_q;
    assign out_addr  = addr_q;
    assign err_count = err_cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// ----------------------------------------------------------------------------
// tb_instr_encoder
//
// Directed bench for instr_encoder: reset state, per-format encodings with
// hand-computed words, range-check errors, backpressure, reset during a stall
// and error-count saturation.
// ----------------------------------------------------------------------------
module tb_instr_encoder;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op_sel;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        out_err;
    logic [7:0]  err_count;

    int checks;
    int errors;

    instr_encoder #(
        .BASE_ADDR(32'h0000_0000)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op_sel   (op_sel),
        .rd       (rd),
        .rs1      (rs1),
        .rs2      (rs2),
        .imm      (imm),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_instr(out_instr),
        .out_addr (out_addr),
        .out_err  (out_err),
        .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic [3:0] op, input logic [4:0] d, input logic [4:0] s1,
                           input logic [4:0] s2, input logic [31:0] im);
        op_sel   = op;
        rd       = d;
        rs1      = s1;
        rs2      = s2;
        imm      = im;
        in_valid = 1'b1;
    endtask

    // Advance one clock and sample just after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] op, input logic [4:0] d, input logic [4:0] s1,
                        input logic [4:0] s2, input logic [31:0] im);
        set_req(op, d, s1, s2, im);
        step();
    endtask

    task automatic expect_word(input string tag, input logic [31:0] instr,
                               input logic [31:0] addr, input logic err);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_instr"}, out_instr, instr);
        check({tag, "_addr"},  out_addr,  addr);
        check({tag, "_err"},   {31'd0, out_err}, {31'd0, err});
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op_sel    = 4'd0;
        rd        = 5'd0;
        rs1       = 5'd0;
        rs2       = 5'd0;
        imm       = 32'd0;

        // ---- Reset, with a request presented that must not be taken ----
        set_req(4'd2, 5'd1, 5'd0, 5'd0, 32'd5);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        step();
        step();
        check("rst_valid",  {31'd0, out_valid}, 32'd0);
        check("rst_instr",  out_instr, 32'h0000_0000);
        check("rst_err",    {31'd0, out_err}, 32'd0);
        check("rst_addr",   out_addr, 32'h0000_0000);
        check("rst_cnt",    {24'd0, err_count}, 32'd0);
        check("rst_ready",  {31'd0, in_ready}, 32'd1);
        rst      = 1'b0;
        in_valid = 1'b0;
        step();
        check("no_accept_in_rst", {31'd0, out_valid}, 32'd0);

        // ---- Legal encodings, streaming with out_ready=1 ----
        send(4'd2,  5'd1, 5'd0, 5'd0, 32'd5);
        expect_word("addi", 32'h0050_0093, 32'h00, 1'b0);
        send(4'd0,  5'd3, 5'd1, 5'd2, 32'd0);
        expect_word("add", 32'h0020_81B3, 32'h04, 1'b0);
        send(4'd8,  5'd0, 5'd1, 5'd0, 32'hFFFF_FFFC);
        expect_word("bne", 32'hFE00_9EE3, 32'h08, 1'b0);
        send(4'd7,  5'd5, 5'd0, 5'd0, 32'h1234_5000);
        expect_word("lui", 32'h1234_52B7, 32'h0C, 1'b0);
        send(4'd1,  5'd3, 5'd1, 5'd2, 32'd0);
        check("sub_instr", out_instr, 32'h4020_81B3);
        send(4'd6,  5'd0, 5'd2, 5'd5, 32'd8);
        check("sw_instr", out_instr, 32'h0051_2423);
        send(4'd4,  5'd6, 5'd2, 5'd0, 32'hFFFF_FFFF);
        check("lw_instr", out_instr, 32'hFFF1_2303);
        send(4'd10, 5'd1, 5'd0, 5'd0, 32'd8);
        check("jal_instr", out_instr, 32'h0080_00EF);
        send(4'd13, 5'd1, 5'd2, 5'd0, 32'd3);
        check("srai_instr", out_instr, 32'h4031_5093);
        send(4'd11, 5'd0, 5'd1, 5'd0, 32'd0);
        check("jalr_instr", out_instr, 32'h0000_8067);
        send(4'd9,  5'd0, 5'd1, 5'd2, 32'd4094);
        expect_word("bgeu_max", 32'h7E20_FFE3, 32'h28, 1'b0);
        send(4'd2,  5'd1, 5'd0, 5'd0, 32'hFFFF_F800);
        expect_word("addi_min", 32'h8000_0093, 32'h2C, 1'b0);
        send(4'd3,  5'd7, 5'd3, 5'd0, 32'd1);
        check("lbu_instr", out_instr, 32'h0011_C383);
        send(4'd12, 5'd2, 5'd2, 5'd0, 32'd31);
        expect_word("slli_max", 32'h01F1_1113, 32'h34, 1'b0);
        send(4'd10, 5'd0, 5'd0, 5'd0, 32'hFFF0_0000);
        expect_word("jal_min", 32'h8000_006F, 32'h38, 1'b0);
        in_valid = 1'b0;
        step();
        check("drain_valid", {31'd0, out_valid}, 32'd0);
        check("drain_addr",  out_addr, 32'h3C);
        check("drain_cnt",   {24'd0, err_count}, 32'd0);

        // ---- Error substitution ----
        rst = 1'b1;
        step();
        rst = 1'b0;
        send(4'd2,  5'd1, 5'd0, 5'd0, 32'd4096);
        expect_word("err_addi", 32'h0000_0013, 32'h00, 1'b1);
        send(4'd8,  5'd0, 5'd1, 5'd0, 32'd3);
        expect_word("err_bne_odd", 32'h0000_0013, 32'h04, 1'b1);
        send(4'd15, 5'd1, 5'd1, 5'd1, 32'd0);
        expect_word("err_op15", 32'h0000_0013, 32'h08, 1'b1);
        check("err_cnt2", {24'd0, err_count}, 32'd2);
        send(4'd12, 5'd1, 5'd1, 5'd0, 32'd32);
        expect_word("err_slli", 32'h0000_0013, 32'h0C, 1'b1);
        check("err_cnt3", {24'd0, err_count}, 32'd3);
        send(4'd7,  5'd5, 5'd0, 5'd0, 32'h1234_5001);
        check("err_lui", {31'd0, out_err}, 32'd1);
        send(4'd10, 5'd1, 5'd0, 5'd0, 32'h0010_0000);
        check("err_jal", {31'd0, out_err}, 32'd1);
        send(4'd2,  5'd1, 5'd0, 5'd0, 32'd2048);
        check("err_addi_2048", {31'd0, out_err}, 32'd1);
        send(4'd9,  5'd0, 5'd1, 5'd2, 32'hFFFF_EFFE);
        expect_word("err_bgeu_low", 32'h0000_0013, 32'h1C, 1'b1);
        in_valid = 1'b0;
        step();
        check("err_cnt8", {24'd0, err_count}, 32'd8);
        check("err_addr_end", out_addr, 32'h20);

        // ---- Backpressure ----
        rst = 1'b1;
        step();
        rst       = 1'b0;
        out_ready = 1'b0;
        send(4'd2, 5'd1, 5'd0, 5'd0, 32'd5);
        expect_word("bp_first", 32'h0050_0093, 32'h00, 1'b0);
        set_req(4'd0, 5'd3, 5'd1, 5'd2, 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            expect_word("bp_hold", 32'h0050_0093, 32'h00, 1'b0);
        end
        out_ready = 1'b1;
        step();
        expect_word("bp_second", 32'h0020_81B3, 32'h04, 1'b0);
        send(4'd1, 5'd3, 5'd1, 5'd2, 32'd0);
        expect_word("bp_third", 32'h4020_81B3, 32'h08, 1'b0);
        in_valid = 1'b0;
        step();
        check("bp_drain_valid", {31'd0, out_valid}, 32'd0);
        check("bp_drain_addr",  out_addr, 32'h0C);

        // ---- Reset while a word is stalled ----
        send(4'd15, 5'd0, 5'd0, 5'd0, 32'd0);
        in_valid = 1'b0;
        step();
        check("pre_rst_cnt", {24'd0, err_count}, 32'd1);
        out_ready = 1'b0;
        send(4'd0, 5'd3, 5'd1, 5'd2, 32'd0);
        in_valid = 1'b0;
        check("stall_valid", {31'd0, out_valid}, 32'd1);
        rst = 1'b1;
        #1;
        check("stall_rst_ready", {31'd0, in_ready}, 32'd1);
        step();
        check("stall_rst_valid", {31'd0, out_valid}, 32'd0);
        check("stall_rst_addr",  out_addr, 32'h00);
        check("stall_rst_cnt",   {24'd0, err_count}, 32'd0);
        rst       = 1'b0;
        out_ready = 1'b1;
        send(4'd2, 5'd1, 5'd0, 5'd0, 32'd5);
        expect_word("post_rst", 32'h0050_0093, 32'h00, 1'b0);

        // ---- Error count saturation ----
        set_req(4'd14, 5'd0, 5'd0, 5'd0, 32'd0);
        for (int i = 0; i < 300; i++) begin
            step();
        end
        in_valid = 1'b0;
        step();
        check("sat_cnt",   {24'd0, err_count}, 32'd255);
        check("sat_addr",  out_addr, 32'h0000_04B4);
        check("sat_valid", {31'd0, out_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
